mult_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one sequential add-shift binary multiplier among NREQ requesters. Each requester uses a request/grant handshake. The block latches the winner's operands, pulses the multiplier's start, and tracks the multiplier's rdy. It returns the product on a shared result bus, tagged with the requester index. A watchdog flags a multiplier that never completes.

---
 rtl/mult_arb_pkg.sv | 19 +
 rtl/mult_arb_rr_pick.sv | 40 ++++
 rtl/mult_share_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared state type and default sizing for the multiplier-sharing arbiter
package mult_arb_pkg;

  localparam int NREQ_DEF       = 4;
  localparam int DP_WIDTH_DEF   = 5;
  localparam int TMO_CYCLES_DEF = 64;
  localparam int ID_W_DEF       = $clog2(NREQ_DEF);

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DELIVER   = 3'd4
  } state_e;

endpackage

// File: rtl/mult_arb_rr_pick.sv
// rtl/mult_arb_rr_pick.sv - combinational round-robin picker
// Searches req_i upward from ptr_i with wrap; first set bit wins.
module mult_arb_rr_pick
  import mult_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] win_onehot_o,
  output logic [ID_W-1:0] win_id_o,
  output logic            any_req_o
);

  logic [ID_W:0] idx;
  logic          found;

  always_comb begin
    win_onehot_o = '0;
    win_id_o     = '0;
    found        = 1'b0;
    idx          = '0;
    for (int k = 0; k < NREQ; k++) begin
      // one extra bit so ptr+k cannot overflow before the wrap subtraction
      idx = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NREQ)) begin
        idx = idx - (ID_W+1)'(NREQ);
      end
      if (!found && req_i[idx[ID_W-1:0]]) begin
        found                          = 1'b1;
        win_onehot_o[idx[ID_W-1:0]]    = 1'b1;
        win_id_o                       = idx[ID_W-1:0];
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - shares one sequential multiplier among NREQ requesters
// Round-robin grant, operand latch, start/rdy sequencing, tagged result and watchdog.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int DP_WIDTH   = DP_WIDTH_DEF,
  parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DP_WIDTH-1:0] a_in,
  input  logic [NREQ*DP_WIDTH-1:0] b_in,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [2*DP_WIDTH-1:0]    res,
  output logic                     res_err,
  output logic                     err,
  output logic                     busy,
  output logic                     mul_start,
  output logic [DP_WIDTH-1:0]      mul_multiplicand,
  output logic [DP_WIDTH-1:0]      mul_multiplier,
  input  logic                     mul_rdy,
  input  logic [2*DP_WIDTH-1:0]    mul_product
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int PW    = 2*DP_WIDTH;
  localparam int CNT_W = $clog2(TMO_CYCLES+1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DP_WIDTH-1:0] a_q, a_d;
  logic [DP_WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]       res_q, res_d;
  logic                tmo_q, tmo_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NREQ-1:0]     pick_onehot;
  logic [ID_W-1:0]     pick_id;
  logic                any_req;
  logic [DP_WIDTH-1:0] a_sel, b_sel;
  logic                tmo_hit;

  mult_arb_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req_i        (req),
    .ptr_i        (ptr_q),
    .win_onehot_o (pick_onehot),
    .win_id_o     (pick_id),
    .any_req_o    (any_req)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_onehot[i]) begin
        a_sel = a_in[i*DP_WIDTH +: DP_WIDTH];
        b_sel = b_in[i*DP_WIDTH +: DP_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tmo_hit = (cnt_q == CNT_W'(TMO_CYCLES-1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    gnt       = '0;
    done      = '0;
    mul_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req && mul_rdy) begin
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = pick_id;
          ptr_d   = (pick_id == ID_W'(NREQ-1)) ? '0 : pick_id + 1'b1;
          tmo_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        gnt[id_q] = 1'b1;
        mul_start = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // rdy still high here is the previous product; wait for it to drop
        if (tmo_hit) begin
          res_d   = '0;
          tmo_d   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_DELIVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!mul_rdy) begin
            state_d = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (mul_rdy) begin
          res_d   = mul_product;
          state_d = ST_DELIVER;
        end else if (tmo_hit) begin
          res_d   = '0;
          tmo_d   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_DELIVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DELIVER: begin
        done[id_q] = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy             = (state_q != ST_IDLE);
  assign res_err          = (state_q == ST_DELIVER) && tmo_q;
  assign res              = res_q;
  assign err              = err_q;
  assign mul_multiplicand = a_q;
  assign mul_multiplier   = b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - self-checking bench for mult_share_arbiter
// Behavioural multiplier plus a queue scoreboard and round-robin reference model.
module tb_mult_share_arbiter;

  localparam int N   = 4;
  localparam int W   = 5;
  localparam int PW  = 2*W;
  localparam int TMO = 64;

  typedef struct {
    int            id;
    logic [PW-1:0] prod;
    logic          err;
  } job_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*W-1:0]  a_in, b_in;
  logic [N-1:0]    gnt, done;
  logic [PW-1:0]   res;
  logic            res_err, err, busy, mul_start;
  logic [W-1:0]    mul_multiplicand, mul_multiplier;
  logic            mul_rdy = 1'b1;
  logic [PW-1:0]   mul_product = '0;

  int errors = 0, checks = 0;
  int starts = 0, grants = 0, ndone = 0, cycle = 0;
  int rr_m = 0, gnt_cycle = 0, done_cycle = 0, lat = 3;
  logic stuck = 1'b0, hold = 1'b0;
  logic [W-1:0]  a_v [N];
  logic [W-1:0]  b_v [N];
  job_t          sb[$];
  int            glog[$];
  int            dlog_id[$];
  logic [PW-1:0] dlog_res[$];
  logic [PW-1:0] last_res;
  logic          last_err;

  logic          mbusy = 1'b0;
  int            mcnt = 0;
  logic [PW-1:0] ma = '0, mb = '0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NREQ(N), .DP_WIDTH(W), .TMO_CYCLES(TMO)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .a_in             (a_in),
    .b_in             (b_in),
    .gnt              (gnt),
    .done             (done),
    .res              (res),
    .res_err          (res_err),
    .err              (err),
    .busy             (busy),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_rdy          (mul_rdy),
    .mul_product      (mul_product)
  );

  // Sequential multiplier: rdy low for lat+1 cycles after start, garbage product meanwhile.
  always @(posedge clk) begin
    if (mbusy) begin
      if (mcnt == 0) begin
        mul_rdy     <= 1'b1;
        mul_product <= ma * mb;
        mbusy       <= 1'b0;
      end else begin
        mcnt        <= mcnt - 1;
        mul_product <= PW'($urandom);
      end
    end else if (mul_start && !stuck) begin
      ma          <= PW'(mul_multiplicand);
      mb          <= PW'(mul_multiplier);
      mul_rdy     <= 1'b0;
      mcnt        <= lat;
      mbusy       <= 1'b1;
      mul_product <= PW'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = a_v[i];
      b_in[i*W +: W] = b_v[i];
    end
  endtask

  // One cycle: advance to next falling edge and score any grant / done seen there.
  task automatic tick();
    logic [N-1:0] snap;
    logic         snap_rdy;
    logic [N-1:0] exp_g;
    int           win;
    job_t         j;
    snap     = req;
    snap_rdy = mul_rdy;
    @(negedge clk);
    cycle++;
    if (mul_start) starts++;
    if (gnt != '0) begin
      grants++;
      win = -1;
      if (snap_rdy) begin
        for (int k = 0; k < N; k++) begin
          if (win < 0 && snap[(rr_m + k) % N]) win = (rr_m + k) % N;
        end
      end
      exp_g = (win < 0) ? '0 : (N'(1) << win);
      chk("gnt_winner", 32'(gnt), 32'(exp_g));
      chk("start_with_gnt", 32'(mul_start), 32'd1);
      if (win >= 0) begin
        chk("mul_a", 32'(mul_multiplicand), 32'(a_v[win]));
        chk("mul_b", 32'(mul_multiplier), 32'(b_v[win]));
        j.id   = win;
        j.err  = stuck;
        j.prod = stuck ? '0 : PW'(a_v[win]) * PW'(b_v[win]);
        sb.push_back(j);
        glog.push_back(win);
        rr_m      = (win + 1) % N;
        gnt_cycle = cycle;
        if (!hold) req[win] = 1'b0;
      end
    end
    if (done != '0) begin
      ndone++;
      last_res   = res;
      last_err   = res_err;
      done_cycle = cycle;
      dlog_res.push_back(res);
      dlog_id.push_back($clog2(32'(done)));
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'd0);
      end else begin
        j = sb.pop_front();
        chk("done_id", 32'(done), 32'(N'(1) << j.id));
        chk("done_res", 32'(res), 32'(j.prod));
        chk("done_res_err", 32'(res_err), 32'(j.err));
      end
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (ndone < target && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_wait"}, 32'(ndone >= target), 32'd1);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    hold = 1'b0;
    sb.delete();
    rr_m = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: run exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int n0, g0, s0, n, d;
    int exp_ord [6];
    exp_ord = '{0, 1, 2, 3, 0, 1};

    rst = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    pack();
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(mul_start), 32'd0);
    chk("rst_mcand", 32'(mul_multiplicand), 32'd0);
    chk("rst_mplier", 32'(mul_multiplier), 32'd0);
    rst = 1'b0;

    // single request, rdy low for 10 cycles
    lat = 9;
    a_v[0] = 5'd7; b_v[0] = 5'd9; pack();
    req[0] = 1'b1;
    s0 = starts;
    tick();
    chk("t1_gnt_next_cycle", 32'(gnt), 32'd1);
    wait_done(ndone + 1, 100, "t1");
    chk("t1_res", 32'(last_res), 32'd63);
    chk("t1_res_err", 32'(last_err), 32'd0);
    chk("t1_starts", 32'(starts - s0), 32'd1);
    chk("t1_latency", 32'(done_cycle - gnt_cycle), 32'd12);

    // simultaneous requests 0 and 2
    do_reset();
    lat = 2;
    a_v[0] = 5'd3; b_v[0] = 5'd4; a_v[2] = 5'd5; b_v[2] = 5'd6; pack();
    n0 = ndone; g0 = grants; s0 = starts;
    req = 4'b0101;
    wait_done(n0 + 2, 200, "t2");
    chk("t2_first_id", 32'(dlog_id[n0]), 32'd0);
    chk("t2_first_res", 32'(dlog_res[n0]), 32'd12);
    chk("t2_second_id", 32'(dlog_id[n0+1]), 32'd2);
    chk("t2_second_res", 32'(dlog_res[n0+1]), 32'd30);
    chk("t2_grants", 32'(grants - g0), 32'd2);
    chk("t2_starts", 32'(starts - s0), 32'd2);

    // fairness with all requests held
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_v[i] = W'(i + 2);
      b_v[i] = W'(3*i + 5);
    end
    pack();
    n0 = ndone; g0 = grants;
    hold = 1'b1;
    req  = '1;
    n = 0;
    while (grants - g0 < 6 && n < 600) begin
      tick();
      n++;
    end
    req  = '0;
    hold = 1'b0;
    chk("t3_six_grants", 32'(grants - g0), 32'd6);
    wait_done(n0 + 6, 100, "t3");
    for (int k = 0; k < 6; k++) begin
      if (g0 + k < glog.size()) chk("t3_order", 32'(glog[g0+k]), 32'(exp_ord[k]));
    end

    // exhaustive operand sweep on requester 3
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        lat = $urandom_range(0, 3);
        a_v[3] = W'(a); b_v[3] = W'(b); pack();
        req[3] = 1'b1;
        wait_done(ndone + 1, 60, "t4");
        if (a == 31 && b == 31) chk("t4_31x31", 32'(last_res), 32'd961);
        if (a == 0 && b == 31) chk("t4_0x31", 32'(last_res), 32'd0);
      end
    end

    // randomized traffic from all requesters
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 5) == 0) begin
          a_v[i] = W'($urandom);
          b_v[i] = W'($urandom);
          req[i] = 1'b1;
        end
      end
      pack();
      lat = $urandom_range(0, 6);
      tick();
    end
    n = 0;
    while ((req != '0 || sb.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk("rand_drain", 32'(req == '0 && sb.size() == 0), 32'd1);

    // watchdog: multiplier never drops rdy
    stuck = 1'b1;
    a_v[1] = 5'd3; b_v[1] = 5'd7; pack();
    req[1] = 1'b1;
    wait_done(ndone + 1, TMO + 40, "t5");
    d = done_cycle - gnt_cycle;
    chk("t5_res", 32'(last_res), 32'd0);
    chk("t5_res_err", 32'(last_err), 32'd1);
    chk("t5_latency", 32'(d >= TMO && d <= TMO + 2), 32'd1);
    tick();
    tick();
    chk("t5_err_sticky", 32'(err), 32'd1);
    chk("t5_res_err_drop", 32'(res_err), 32'd0);
    stuck = 1'b0;
    lat = 4;
    a_v[1] = 5'd6; b_v[1] = 5'd7; pack();
    req[1] = 1'b1;
    wait_done(ndone + 1, 60, "t5b");
    chk("t5_next_res", 32'(last_res), 32'd42);
    chk("t5_next_res_err", 32'(last_err), 32'd0);
    chk("t5_err_still", 32'(err), 32'd1);

    // asynchronous reset in the middle of a job
    do_reset();
    chk("t6_err_cleared", 32'(err), 32'd0);
    lat = 20;
    a_v[0] = 5'd5; b_v[0] = 5'd5; pack();
    req[0] = 1'b1;
    g0 = grants;
    n = 0;
    while (grants == g0 && n < 20) begin
      tick();
      n++;
    end
    repeat (5) tick();
    chk("t6_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_gnt", 32'(gnt), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_start", 32'(mul_start), 32'd0);
    chk("t6_mcand", 32'(mul_multiplicand), 32'd0);
    chk("t6_mplier", 32'(mul_multiplier), 32'd0);
    chk("t6_res", 32'(res), 32'd0);
    sb.delete();
    rr_m = 0;
    req  = '0;
    n0 = ndone;
    repeat (3) tick();
    rst = 1'b0;
    repeat (25) tick();
    chk("t6_no_done", 32'(ndone - n0), 32'd0);
    lat = 3;
    a_v[2] = 5'd2; b_v[2] = 5'd3; pack();
    req[2] = 1'b1;
    wait_done(ndone + 1, 60, "t6");
    chk("t6_res_after", 32'(last_res), 32'd6);
    chk("t6_id_after", 32'(dlog_id[dlog_id.size()-1]), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
